// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage and its multiply/divide unit.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASS2 = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_funct_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // Two's-complement negate when n is set.
    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? -v : v;
    endfunction

endpackage

// File: rtl/ex_stage_md_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add multiply and
// restoring divide, one bit per cycle, with sign fixup applied in DONE.
// EX_FAST_MUL_EN: multiplies complete with one registered 33x33 product.
module md_unit
    import ex_pkg::*;
(
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        start_i,
    input  logic [2:0]  funct_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    md_state_e   state_q;
    md_funct_e   funct_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;    // mul: {hi, multiplier}; div: {remainder, quotient}
    logic [31:0] opb_q;    // multiplicand or divisor magnitude
    logic        qneg_q;   // sign of product / quotient
    logic        rneg_q;   // sign of remainder

    md_funct_e   funct;
    logic        is_div, s1, s2, a_neg, b_neg, div_zero, div_ovf;
    logic [31:0] mag1, mag2;

    // Decode signedness of each operand and catch the divide special cases.
    always_comb begin
        funct    = md_funct_e'(funct_i);
        is_div   = funct_i[2];
        s1       = is_div ? ~funct_i[0] : (funct != MD_MULHU);
        s2       = is_div ? ~funct_i[0] : (funct == MD_MUL || funct == MD_MULH);
        a_neg    = s1 & op1_i[31];
        b_neg    = s2 & op2_i[31];
        mag1     = neg_if(a_neg, op1_i);
        mag2     = neg_if(b_neg, op2_i);
        div_zero = (op2_i == 32'd0);
        div_ovf  = s1 && (op1_i == INT_MIN) && (op2_i == 32'hFFFF_FFFF);
    end

    logic [32:0] mul_sum, div_rem, div_sub;
    logic [63:0] mul_next, div_next;
    logic        div_ge;

    // One iteration step of each algorithm.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
        div_rem  = acc_q[63:31];
        div_ge   = (div_rem >= {1'b0, opb_q});
        div_sub  = div_rem - {1'b0, opb_q};
        div_next = {(div_ge ? div_sub[31:0] : div_rem[31:0]), acc_q[30:0], div_ge};
    end

`ifdef EX_FAST_MUL_EN
    logic signed [63:0] fast_a, fast_b, fast_prod;
    // Operands sign-extended from 33 bits; the low 64 product bits are exact.
    always_comb begin
        fast_a    = {{32{a_neg}}, op1_i};
        fast_b    = {{32{b_neg}}, op2_i};
        fast_prod = fast_a * fast_b;
    end
`endif

    // Control FSM with counter and accumulators.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= S_IDLE;
            funct_q <= MD_MUL;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opb_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    funct_q <= funct;
                    cnt_q   <= 5'd0;
                    qneg_q  <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    if (is_div) begin
                        if (div_zero) begin
                            acc_q   <= {op1_i, DIV_ZERO_Q};
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else if (div_ovf) begin
                            acc_q   <= {32'd0, INT_MIN};
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            acc_q   <= {32'd0, mag1};
                            opb_q   <= mag2;
                            state_q <= S_DIV;
                        end
                    end else begin
`ifdef EX_FAST_MUL_EN
                        acc_q   <= fast_prod;
                        qneg_q  <= 1'b0;
                        state_q <= S_DONE;
`else
                        acc_q   <= {32'd0, mag2};
                        opb_q   <= mag1;
                        state_q <= S_MUL;
`endif
                    end
                end
                S_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_DONE;
                end
                S_DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_DONE;
                end
                S_DONE: if (!hold_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [63:0] mul_fix;

    // Sign fixup and word select of the finished result.
    always_comb begin
        mul_fix = qneg_q ? -acc_q : acc_q;
        case (funct_q)
            MD_MUL:                       result_o = mul_fix[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_o = mul_fix[63:32];
            MD_DIV, MD_DIVU:              result_o = neg_if(qneg_q, acc_q[31:0]);
            default:                      result_o = neg_if(rneg_q, acc_q[63:32]);
        endcase
    end

    assign busy_o = ((state_q == S_IDLE) && start_i) || (state_q == S_MUL) || (state_q == S_DIV);
    assign done_o = (state_q == S_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU plus the multi-cycle RV32M unit.
// Build option EX_FAST_MUL_EN selects the single-cycle multiplier in md_unit.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            in_valid,
    input  logic [3:0]      alu_op,
    input  logic [3:0]      md_op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    input  logic            hold,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            busy
);

    logic [XLEN-1:0] alu_res, md_res;
    logic [4:0]      shamt;
    logic            md_busy, md_done;

    assign shamt = operand2[4:0];

    // Single-cycle ALU; unused encodings give zero.
    always_comb begin
        case (alu_op_e'(alu_op))
            ALU_ADD:   alu_res = operand1 + operand2;
            ALU_SUB:   alu_res = operand1 - operand2;
            ALU_SLL:   alu_res = operand1 << shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, operand1 < operand2};
            ALU_XOR:   alu_res = operand1 ^ operand2;
            ALU_SRL:   alu_res = operand1 >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(operand1) >>> shamt);
            ALU_OR:    alu_res = operand1 | operand2;
            ALU_AND:   alu_res = operand1 & operand2;
            ALU_PASS2: alu_res = operand2;
            default:   alu_res = '0;
        endcase
    end

    md_unit u_md (
        .clk_i    (clk),
        .nrst_i   (nrst),
        .start_i  (in_valid & md_op[3]),
        .funct_i  (md_op[2:0]),
        .op1_i    (operand1),
        .op2_i    (operand2),
        .flush_i  (flush),
        .hold_i   (hold),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_res)
    );

    // Result mux; a finished M result takes priority, outputs held at zero in reset.
    always_comb begin
        result       = '0;
        result_valid = 1'b0;
        busy         = 1'b0;
        if (nrst) begin
            busy         = md_busy;
            result       = md_done ? md_res : alu_res;
            result_valid = md_done | (in_valid & ~md_op[3]);
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;
    import ex_pkg::*;

`ifdef EX_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] operand1 = 32'd0;
    logic [31:0] operand2 = 32'd0;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .in_valid     (in_valid),
        .alu_op       (alu_op),
        .md_op        (md_op),
        .operand1     (operand1),
        .operand2     (operand2),
        .flush        (flush),
        .hold         (hold),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  alu;
        logic [3:0]  md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [3:0] alu, logic [3:0] md,
                                logic [31:0] a, logic [31:0] b, logic [31:0] e, int lat);
        vec_t v;
        v.name = n; v.alu = alu; v.md = md; v.a = a; v.b = b; v.exp = e; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one instruction at a falling edge, hold it until its result
    // appears, then retire it; returns at a falling edge.
    task automatic run_op(input vec_t v);
        int cyc;
        int nb;
        alu_op   = v.alu;
        md_op    = v.md;
        operand1 = v.a;
        operand2 = v.b;
        in_valid = 1'b1;
        cyc = 0;
        nb  = 0;
        #1;
        while (!result_valid && cyc < 100) begin
            if (busy) nb++;
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({v.name, " latency"}, cyc, v.lat);
        chk({v.name, " busy cycles"}, nb, v.lat);
        chk({v.name, " busy at result"}, {31'd0, busy}, 32'd0);
        chk({v.name, " result"}, result, v.exp);
        @(negedge clk);
        in_valid = 1'b0;
        md_op    = 4'd0;
        alu_op   = 4'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;

        // Reset holds every output low even with a live ALU op presented.
        alu_op = 4'd0; operand1 = 32'd1; operand2 = 32'd2; in_valid = 1'b1;
        #12;
        chk("reset result", result, 32'd0);
        chk("reset result_valid", {31'd0, result_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        vecs.push_back(mk("ADD ovf",   4'd0,  4'h0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 0));
        vecs.push_back(mk("SUB",       4'd1,  4'h0, 32'd5,         32'd7,         32'hFFFF_FFFE, 0));
        vecs.push_back(mk("SLL",       4'd2,  4'h0, 32'd1,         32'h23,        32'd8,         0));
        vecs.push_back(mk("SLT",       4'd3,  4'h0, 32'hFFFF_FFFF, 32'd1,         32'd1,         0));
        vecs.push_back(mk("SLTU",      4'd4,  4'h0, 32'hFFFF_FFFF, 32'd1,         32'd0,         0));
        vecs.push_back(mk("XOR",       4'd5,  4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0));
        vecs.push_back(mk("SRL",       4'd6,  4'h0, 32'h8000_0000, 32'd4,         32'h0800_0000, 0));
        vecs.push_back(mk("SRA",       4'd7,  4'h0, 32'h8000_0000, 32'd4,         32'hF800_0000, 0));
        vecs.push_back(mk("OR",        4'd8,  4'h0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0));
        vecs.push_back(mk("AND",       4'd9,  4'h0, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 0));
        vecs.push_back(mk("PASS2",     4'd10, 4'h0, 32'd3,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk("unused op", 4'd15, 4'h0, 32'd3,         32'd4,         32'd0,         0));
        vecs.push_back(mk("DIV -7/2",  4'd0,  4'hC, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33));
        vecs.push_back(mk("REM -7%2",  4'd0,  4'hE, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33));
        vecs.push_back(mk("DIVU 5/0",  4'd0,  4'hD, 32'd5,         32'd0,         32'hFFFF_FFFF, 1));
        vecs.push_back(mk("REMU 5/0",  4'd0,  4'hF, 32'd5,         32'd0,         32'd5,         1));
        vecs.push_back(mk("REM min/-1",4'd0,  4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1));
        vecs.push_back(mk("DIV min/-1",4'd0,  4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1));
        vecs.push_back(mk("DIVU 100/7",4'd0,  4'hD, 32'd100,       32'd7,         32'd14,        33));
        vecs.push_back(mk("REMU 100%7",4'd0,  4'hF, 32'd100,       32'd7,         32'd2,         33));
        vecs.push_back(mk("REM 7%-2",  4'd0,  4'hE, 32'd7,         32'hFFFF_FFFE, 32'd1,         33));
        vecs.push_back(mk("MULH min2", 4'd0,  4'h9, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT));
        vecs.push_back(mk("MUL 7*-3",  4'd0,  4'h8, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT));
        vecs.push_back(mk("MULHU max", 4'd0,  4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT));
        vecs.push_back(mk("MULHSU",    4'd0,  4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT));

        foreach (vecs[i]) run_op(vecs[i]);

        // Hold in DONE for three cycles, then the next divide follows at once.
        hold = 1'b1;
        run_op(mk("hold DIVU", 4'd0, 4'hD, 32'd100, 32'd7, 32'd14, 33));
        repeat (2) begin
            #1;
            chk("hold result_valid", {31'd0, result_valid}, 32'd1);
            chk("hold result", result, 32'd14);
            @(negedge clk);
        end
        hold = 1'b0;
        #1;
        chk("hold release valid", {31'd0, result_valid}, 32'd1);
        chk("hold release result", result, 32'd14);
        @(negedge clk);
        run_op(mk("after hold DIV 7/-2", 4'd0, 4'hC, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33));

        // Flush in divide cycle 10 kills the operation without a result.
        alu_op = 4'd0; md_op = 4'hD; operand1 = 32'd100; operand2 = 32'd7; in_valid = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("flush busy before", {31'd0, busy}, 32'd1);
        flush = 1'b1; in_valid = 1'b0; md_op = 4'd0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush busy after", {31'd0, busy}, 32'd0);
        chk("flush valid after", {31'd0, result_valid}, 32'd0);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (result_valid) nv++;
        end
        chk("flush no late result", nv, 32'd0);
        @(negedge clk);

        // Reset pulse in the middle of a multiply.
        alu_op = 4'd0; md_op = 4'hB; operand1 = 32'hFFFF_FFFF; operand2 = 32'hFFFF_FFFF; in_valid = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("midop reset result", result, 32'd0);
        chk("midop reset valid", {31'd0, result_valid}, 32'd0);
        chk("midop reset busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0; md_op = 4'd0;
        @(negedge clk);
        nrst = 1'b1;
        run_op(mk("post reset ADD", 4'd0, 4'h0, 32'd2, 32'd3, 32'd5, 0));
        run_op(mk("post reset DIVU", 4'd0, 4'hD, 32'd100, 32'd7, 32'd14, 33));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
